call_stack: RTL

//   Return-address stack that pairs with the load register on the CPU's call/return path.

---
 rtl/call_stack_if.sv | 19 +
 rtl/call_stack.sv | 60 ++++++
 2 files changed

// File: rtl/call_stack_if.sv
// call_stack_if: push/pop request and stack status bundle for the return-address stack
interface call_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int PTRW = $clog2(DEPTH) + 1;
  logic             push;
  logic             pop;
  logic             clr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] out;
  logic             empty;
  logic             full;
  logic [PTRW-1:0]  count;
  logic             ovf;
  logic             unf;
  modport master (output push, pop, clr, data, input out, empty, full, count, ovf, unf);
  modport slave  (input push, pop, clr, data, output out, empty, full, count, ovf, unf);
endinterface

// File: rtl/call_stack.sv
// call_stack: LIFO return-address stack with sticky overflow/underflow flags
module call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  call_stack_if.slave  bus
);
  localparam int PTRW = $clog2(DEPTH) + 1;
  localparam int AW   = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  cnt;
  logic [PTRW-1:0]  cnt_m1;
  logic [AW-1:0]    widx;
  logic             empty;
  logic             full;
  logic             we;
  logic             ovf_q;
  logic             unf_q;
  assign cnt_m1 = cnt - 1'b1;
  assign empty  = cnt == '0;
  assign full   = cnt == PTRW'(DEPTH);
  // push+pop on a non-empty stack overwrites the top; otherwise write the next free slot
  assign widx   = (bus.pop && !empty) ? cnt_m1[AW-1:0] : cnt[AW-1:0];
  assign we     = rst_n && bus.push && (bus.pop || !full);
  assign bus.out   = empty ? '0 : mem[cnt_m1[AW-1:0]];
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.count = cnt;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  always_ff @(posedge clk)
    if (we) mem[widx] <= bus.data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      // error assignments come after clr so a same-cycle error keeps its flag set
      if (bus.push && bus.pop) begin
        if (empty) begin
          cnt   <= PTRW'(1);
          unf_q <= 1'b1;
        end
      end else if (bus.push) begin
        if (full) ovf_q <= 1'b1;
        else cnt <= cnt + 1'b1;
      end else if (bus.pop) begin
        if (empty) unf_q <= 1'b1;
        else cnt <= cnt_m1;
      end
    end
  end
endmodule
